// File: rtl/sha_pad_pkg.sv
// Shared types and constants for the streaming SHA-2 message padder.
package sha_pad_pkg;

  typedef enum logic [2:0] {
    FILL,
    OUT,
    PADOUT,
    OUTX,
    FINAL
  } pad_state_e;

  localparam logic [7:0] PAD_MARKER = 8'h80;

  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_LEN_W   = 64;
  localparam int SHA512_BLOCK_W = 1024;
  localparam int SHA512_LEN_W   = 128;

endpackage

// File: rtl/sha_pad_if.sv
// Beat-in / block-out valid/ready bundle between the header logic, padder and compression core.
interface sha_pad_if #(
  parameter int IN_W    = 32,
  parameter int BLOCK_W = 512
);
  localparam int BYTES_W = $clog2(IN_W / 8) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic               in_last;
  logic [BYTES_W-1:0] in_bytes;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               out_last;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sha_pad_byte_place.sv
// Drops one beat into the block buffer at a byte pointer; on a final beat also writes
// the 0x80 marker right after the data and clears every byte beyond it.
module sha_pad_byte_place
  import sha_pad_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int BLOCK_W = 512,
  parameter int PTR_W   = 7,
  parameter int BYTES_W = 3
) (
  input  logic [BLOCK_W-1:0] buf_in,
  input  logic [PTR_W-1:0]   ptr,
  input  logic [IN_W-1:0]    beat,
  input  logic [BYTES_W-1:0] nbytes,
  input  logic               is_last,
  output logic [BLOCK_W-1:0] buf_out
);

  localparam int NB = BLOCK_W / 8;

  always_comb begin
    int rel;
    int nb;
    buf_out = buf_in;
    nb      = int'(nbytes);
    rel     = 0;
    for (int i = 0; i < NB; i++) begin
      rel = i - int'(ptr);
      if (rel >= 0 && rel < nb) begin
        buf_out[BLOCK_W-1-8*i -: 8] = beat[IN_W-1-8*rel -: 8];
      end else if (is_last && rel == nb) begin
        buf_out[BLOCK_W-1-8*i -: 8] = PAD_MARKER;
      end else if (is_last && rel > nb) begin
        buf_out[BLOCK_W-1-8*i -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha_msg_padder.sv
// Streaming SHA-2 padder: packs message beats into blocks and appends marker, zero fill and bit length.
//
// state  | meaning
// FILL   | accepting beats into the block buffer
// OUT    | full data block presented, more message to come
// PADOUT | last data block (marker, no room for length) presented; length-only block follows
// OUTX   | last data block exactly full presented; marker+length block follows
// FINAL  | closing block carrying the length presented
module sha_msg_padder
  import sha_pad_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int BLOCK_W = SHA256_BLOCK_W,
  parameter int LEN_W   = SHA256_LEN_W
) (
  input  logic      clk,
  input  logic      rst,
  sha_pad_if.slave  bus
);

  localparam int NB      = BLOCK_W / 8;
  localparam int BEAT_B  = IN_W / 8;
  localparam int LEN_B   = LEN_W / 8;
  localparam int PTR_W   = $clog2(NB + 1);
  localparam int BYTES_W = $clog2(BEAT_B) + 1;

  localparam logic [PTR_W-1:0]   NB_P     = PTR_W'(NB);
  localparam logic [PTR_W:0]     NB_X     = (PTR_W + 1)'(NB);
  localparam logic [PTR_W:0]     TAIL_X   = (PTR_W + 1)'(LEN_B + 1);
  localparam logic [BYTES_W-1:0] BEAT_B_W = BYTES_W'(BEAT_B);

  pad_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;

  logic [BYTES_W-1:0] nbytes;
  logic [PTR_W-1:0]   end_ptr;
  logic [LEN_W-1:0]   cnt_sum;
  logic [BLOCK_W-1:0] placed;
  logic               room_for_len;

  // Oversized in_bytes on a final beat is clamped to a full beat.
  always_comb begin
    nbytes = BEAT_B_W;
    if (bus.in_last && bus.in_bytes < BEAT_B_W) begin
      nbytes = bus.in_bytes;
    end
  end

  assign end_ptr      = ptr_q + PTR_W'(nbytes);
  assign cnt_sum      = cnt_q + LEN_W'({nbytes, 3'b000});
  assign room_for_len = ({1'b0, end_ptr} + TAIL_X) <= NB_X;

  sha_pad_byte_place #(
    .IN_W    (IN_W),
    .BLOCK_W (BLOCK_W),
    .PTR_W   (PTR_W),
    .BYTES_W (BYTES_W)
  ) u_place (
    .buf_in  (buf_q),
    .ptr     (ptr_q),
    .beat    (bus.in_data),
    .nbytes  (nbytes),
    .is_last (bus.in_last),
    .buf_out (placed)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          buf_d = placed;
          cnt_d = cnt_sum;
          ptr_d = end_ptr;
          if (bus.in_last) begin
            ptr_d = '0;
            if (end_ptr == NB_P) begin
              state_d = OUTX;
            end else if (room_for_len) begin
              buf_d   = {placed[BLOCK_W-1:LEN_W], cnt_sum};
              state_d = FINAL;
            end else begin
              state_d = PADOUT;
            end
          end else if (end_ptr == NB_P) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = FILL;
          ptr_d   = '0;
        end
      end
      PADOUT: begin
        if (bus.out_ready) begin
          buf_d   = {{(BLOCK_W-LEN_W){1'b0}}, cnt_q};
          state_d = FINAL;
        end
      end
      OUTX: begin
        if (bus.out_ready) begin
          buf_d   = {PAD_MARKER, {(BLOCK_W-LEN_W-8){1'b0}}, cnt_q};
          state_d = FINAL;
        end
      end
      FINAL: begin
        if (bus.out_ready) begin
          state_d = FILL;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q != FILL);
  assign bus.out_last  = (state_q == FINAL);
  assign bus.out_data  = buf_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Scoreboard bench for sha_msg_padder: textbook SHA-256 padding model vs. DUT blocks.
module tb_sha_msg_padder;
  import sha_pad_pkg::*;

  typedef logic [7:0] u8;
  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha_pad_if #(.IN_W(32), .BLOCK_W(512)) bus ();

  sha_msg_padder #(.IN_W(32), .BLOCK_W(512), .LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  blk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stall  = 1'b0;

  // Standard SHA-256 padding: msg | 0x80 | zeros to 56 mod 64 | 64-bit big-endian bit length.
  function automatic void model_push(input u8 m[$]);
    u8            p[$];
    logic [63:0]  bits;
    blk_t         e;
    int           nblk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nblk = p.size() / 64;
    for (int blk = 0; blk < nblk; blk++) begin
      e.data = '0;
      for (int b = 0; b < 64; b++) e.data[511-8*b -: 8] = p[blk*64+b];
      e.last = (blk == nblk - 1);
      exp_q.push_back(e);
    end
  endfunction

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: a block transfers at the next rising edge when valid & ready are seen here.
  initial begin
    blk_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block got=%h", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e.data) begin
            errors++;
            $display("FAIL block_data got=%h exp=%h", bus.out_data, e.data);
          end
          checks++;
          if (bus.out_last !== e.last) begin
            errors++;
            $display("FAIL block_last got=%b exp=%b", bus.out_last, e.last);
          end
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic send_msg(input u8 m[$], input int abort_beat, input bit extra_ok, input bit push_exp);
    int          n;
    int          nbeats;
    int          total;
    int          cnt;
    int          tmo;
    bit          last;
    logic [31:0] d;
    n      = m.size();
    nbeats = (n == 0) ? 1 : (n + 3) / 4;
    total  = nbeats;
    if (extra_ok && n > 0 && n % 4 == 0 && $urandom_range(0, 2) == 0) total = nbeats + 1;
    if (push_exp) model_push(m);
    for (int b = 0; b < total; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      cnt  = (b >= nbeats) ? 0 : ((n - 4*b) > 4 ? 4 : (n - 4*b));
      last = (b == total - 1);
      d    = $urandom;
      for (int j = 0; j < cnt; j++) d[31-8*j -: 8] = m[4*b+j];
      bus.in_data  = d;
      bus.in_last  = last;
      if (!last)
        bus.in_bytes = 3'($urandom_range(0, 7));
      else if (cnt == 4 && $urandom_range(0, 1) == 1)
        bus.in_bytes = 3'($urandom_range(5, 7));
      else
        bus.in_bytes = 3'(cnt);
      bus.in_valid = 1'b1;
      if (b == abort_beat) begin
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        bus.in_valid = 1'b0;
        check_bit("reset_mid_in_ready", bus.in_ready, 1'b1);
        check_bit("reset_mid_out_valid", bus.out_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        return;
      end
      tmo = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && tmo < 2000) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 2000) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout got=in_ready_low exp=in_ready_high");
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int tmo;
    tmo = 0;
    while (exp_q.size() != 0 && tmo < 5000) begin
      @(negedge clk);
      tmo++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d_pending exp=0", exp_q.size());
    end
  endtask

  function automatic void rand_msg(output u8 m[$], input int len);
    m = {};
    for (int i = 0; i < len; i++) m.push_back(u8'($urandom));
  endfunction

  initial begin
    u8            m[$];
    blk_t         e;
    logic [511:0] cap;
    int           tmo;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_bytes = '0;

    #12;
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_out_last", bus.out_last, 1'b0);
    checks++;
    if (bus.out_data !== 512'h0) begin
      errors++;
      $display("FAIL rst_out_data got=%h exp=0", bus.out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // "abc" against a hand-written block
    m = {8'h61, 8'h62, 8'h63};
    e.data = {32'h61626380, 416'h0, 64'h18};
    e.last = 1'b1;
    exp_q.push_back(e);
    send_msg(m, -1, 1'b0, 1'b0);
    drain();

    m = {};
    send_msg(m, -1, 1'b0, 1'b1);
    drain();

    rand_msg(m, 80);
    send_msg(m, -1, 1'b1, 1'b1);
    drain();

    rand_msg(m, 56);
    send_msg(m, -1, 1'b1, 1'b1);
    drain();

    rand_msg(m, 55);
    send_msg(m, -1, 1'b1, 1'b1);
    drain();

    // 64-byte message with the consumer stalled on the first block
    stall = 1'b1;
    rand_msg(m, 64);
    send_msg(m, -1, 1'b0, 1'b1);
    tmo = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    check_bit("stall_out_valid_rise", bus.out_valid, 1'b1);
    cap = bus.out_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_data !== cap) begin
        errors++;
        $display("FAIL stall_data_stable got=%h exp=%h", bus.out_data, cap);
      end
      check_bit("stall_in_ready", bus.in_ready, 1'b0);
      check_bit("stall_out_valid", bus.out_valid, 1'b1);
    end
    stall = 1'b0;
    drain();

    // Reset during beat 10 of an 80-byte message, then "abc" alone
    rand_msg(m, 80);
    send_msg(m, 9, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    m = {8'h61, 8'h62, 8'h63};
    e.data = {32'h61626380, 416'h0, 64'h18};
    e.last = 1'b1;
    exp_q.push_back(e);
    send_msg(m, -1, 1'b0, 1'b0);
    drain();

    for (int r = 0; r < 25; r++) begin
      rand_msg(m, $urandom_range(0, 200));
      send_msg(m, -1, 1'b1, 1'b1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    repeat (3) @(negedge clk);
    check_bit("idle_out_valid", bus.out_valid, 1'b0);
    check_bit("idle_in_ready", bus.in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
- Streaming SHA-2 message padder; generalises the fixed 640-bit header padder to any message length and to both SHA-256 and SHA-512 block geometry.
- Accepts big-endian message beats over valid/ready and emits complete padded blocks over valid/ready.
- Output blocks carry the 0x80 marker, zero fill and the big-endian bit-length field.
- Sits between the header/nonce assembly logic and the compression core.

Parameters:
- IN_W, 32, bits per input beat; multiple of 8; must divide BLOCK_W.
- BLOCK_W, 512, output block width (512 for SHA-256, 1024 for SHA-512).
- LEN_W, 64, length-field width (64 for SHA-256, 128 for SHA-512); also the width of the internal bit counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  padder can accept a beat.
- in_data  in  IN_W  message bytes, first byte in MSBs.
- in_last  in  1  final beat of message.
- in_bytes  in  $clog2(IN_W/8)+1  valid bytes in the final beat, 0..IN_W/8, MSB-aligned; ignored when in_last=0.
- out_valid  out  1  block valid.
- out_ready  in  1  consumer accepts block.
- out_data  out  BLOCK_W  padded block, first message byte at [BLOCK_W-1 -: 8].
- out_last  out  1  final block of message.

Behaviour:
- Reset (rst=0, asynchronous): state FILL, byte pointer=0, bit counter=0, in_ready=1, out_valid=0, out_data=0, out_last=0.
- A beat transfers when in_valid & in_ready; a block transfers when out_valid & out_ready.
- FILL state:
  - Each accepted beat writes into the block buffer at the byte pointer and adds 8*bytes to the bit counter (IN_W/8 bytes, or in_bytes if in_last).
  - Non-last beat that fills the buffer -> OUT.
  - Last beat:
    - Write 0x80 at the next byte position and zero the rest of the buffer.
    - If ≥ LEN_W/8 bytes remain after the 0x80 byte, place the length in the low LEN_W bits -> FINAL.
    - Else -> PADOUT.
  - Last beat that exactly fills the buffer -> OUTX (0x80 goes in the next block).
- OUT: out_valid=1, out_last=0, in_ready=0. On transfer -> FILL, pointer=0.
- FINAL: out_valid=1, out_last=1, in_ready=0. On transfer -> FILL; pointer and counter cleared.
- PADOUT: out_valid=1, out_last=0. On transfer, load a block of zeros with the length in the low LEN_W bits -> FINAL.
- OUTX: out_valid=1, out_last=0. On transfer, load a block of 0x80 followed by zeros with the length in the low bits -> FINAL.
- Latency: out_valid rises the cycle after the beat that completes a block.
- out_data is registered and held stable while out_valid=1 and out_ready=0.
- in_ready is combinational from state only (=1 iff FILL); no input bypass.
- Empty message: in_last=1 with in_bytes=0 at pointer 0 gives one block 0x80, zeros, length 0.
- Bit counter is LEN_W bits and wraps modulo 2^LEN_W. The counter is not saturated and the wrap is not flagged.
- in_bytes > IN_W/8 is illegal; it is clamped to IN_W/8.
- Bytes of in_data below in_bytes are ignored (treated as zero).
- Reset mid-message or mid-output discards all buffered data. No partial block is emitted after reset release.

Decomposition:
- Package sha_pad_pkg holds:
  - State enum {FILL, OUT, PADOUT, OUTX, FINAL}.
  - Pad marker constant 8'h80.
  - Default geometry constants for SHA-256 (512/64) and SHA-512 (1024/128).
- One natural sub-module, sha_pad_byte_place: combinational placement of one beat, the 0x80 marker and the zero mask into the buffer at a given byte pointer. The top level owns the FSM, bit counter and handshakes.

Test Plan:
- "abc": one beat 0x61626300, in_bytes=3, in_last -> one block, out_last=1; word0=0x61626380, words1..14=0, word15=0x00000018.
- Empty message: in_bytes=0, in_last -> single block, word0=0x80000000, all other words 0.
- 80-byte header (20 beats):
  - Block1 = bytes 0..63, out_last=0.
  - Block2 = bytes 64..79, then 0x80000000, zeros, low 64 bits = 0x280, out_last=1.
- 56-byte message (14 beats) -> PADOUT path:
  - Block1 = data, then 0x80 at byte 56, bytes 57..63 = 0.
  - Block2 = all zero except low 64 bits = 0x1C0, out_last only on block2.
- 64-byte message -> OUTX path: block1 = data; block2 word0=0x80000000, low bits = 0x200. Hold out_ready=0 for 5 cycles and check out_data stable, in_ready=0.
- Assert rst=0 mid-way through beat 10, release, send "abc" -> only the "abc" block is produced, with length 0x18.
